// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational 32-bit ALU among
// NUM_REQ requesters; operands are registered into the ALU and the result is returned by handshake.
module alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int GNT_W   = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   input  logic [NUM_REQ*4-1:0]   req_op,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [31:0]            rsp_result,
   output logic [31:0]            alu_a,
   output logic [31:0]            alu_b,
   output logic [3:0]             alu_op,
   input  logic [31:0]            alu_result,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [GNT_W-1:0] rr_ptr;
   logic [GNT_W-1:0] owner;
   logic [GNT_W-1:0] winner;
   logic [GNT_W-1:0] ptr_next;
   logic             found;
   int               idx;

   logic [31:0] a_arr  [NUM_REQ];
   logic [31:0] b_arr  [NUM_REQ];
   logic [3:0]  op_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi]  = req_a[32*gi +: 32];
         assign b_arr[gi]  = req_b[32*gi +: 32];
         assign op_arr[gi] = req_op[4*gi +: 4];
      end
   endgenerate

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = GNT_W'(idx);
         end
      end
   end

   assign ptr_next = (winner == GNT_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   // Gated by rst_n so the accept is withdrawn the instant reset asserts.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && found)
         req_ready[winner] = 1'b1;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         rsp_result <= '0;
         rsp_valid  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  alu_a  <= a_arr[winner];
                  alu_b  <= b_arr[winner];
                  alu_op <= op_arr[winner];
                  owner  <= winner;
                  rr_ptr <= ptr_next;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_valid  <= NUM_REQ'(1) << owner;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready[owner]) begin
                  rsp_valid <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two-requester instance for the main sequence,
// three-requester instance for pointer wrap; a small ALU model answers alu_result.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Two-requester instance
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [63:0] req_a, req_b;
   logic [7:0]  req_op;
   logic [31:0] rsp_result, alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        busy;

   // Three-requester instance
   logic [2:0]  v3, rdy3, rv3, rr3;
   logic [95:0] a3, b3;
   logic [11:0] op3;
   logic [31:0] res3, alu3_a, alu3_b, alu3_result;
   logic [3:0]  alu3_op;
   logic        busy3;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      logic signed [31:0] sa;
      sa = a;
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return sa >>> b[4:0];
         4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         4'd12:   return (a == b) ? 32'd1 : 32'd0;
         4'd13:   return (a != b) ? 32'd1 : 32'd0;
         4'd14:   return b;
         default: return 32'd0;
      endcase
   endfunction

   always_comb alu_result  = alu_f(alu_a, alu_b, alu_op);
   always_comb alu3_result = alu_f(alu3_a, alu3_b, alu3_op);

   alu_arbiter #(.NUM_REQ(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .busy(busy)
   );

   alu_arbiter #(.NUM_REQ(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v3), .req_ready(rdy3),
      .req_a(a3), .req_b(b3), .req_op(op3),
      .rsp_valid(rv3), .rsp_ready(rr3), .rsp_result(res3),
      .alu_a(alu3_a), .alu_b(alu3_b), .alu_op(alu3_op), .alu_result(alu3_result),
      .busy(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
      v3 = '0; rr3 = 3'b111; a3 = '0; b3 = '0; op3 = '0;
      #2;
      chk("rst_req_ready",  32'(req_ready), 32'h0);
      chk("rst_rsp_valid",  32'(rsp_valid), 32'h0);
      chk("rst_busy",       32'(busy),      32'h0);
      chk("rst_rsp_result", rsp_result,     32'h0);
      chk("rst_alu_a",      alu_a,          32'h0);
      chk("rst_alu_op",     32'(alu_op),    32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single ADD from requester 0
      req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd3}; req_op = 8'h00; req_valid = 2'b01;
      #1;
      chk("single_grant", 32'(req_ready), 32'h1);
      chk("single_busy0", 32'(busy),      32'h0);
      tick();
      chk("single_exec_ready", 32'(req_ready), 32'h0);
      chk("single_exec_busy",  32'(busy),      32'h1);
      chk("single_alu_a",      alu_a,          32'd5);
      chk("single_alu_b",      alu_b,          32'd3);
      req_valid = 2'b00;
      tick();
      chk("single_rsp_valid",  32'(rsp_valid), 32'h1);
      chk("single_rsp_result", rsp_result,     32'd8);
      rsp_ready = 2'b01;
      tick();
      chk("single_rsp_clear",  32'(rsp_valid), 32'h0);
      chk("single_idle",       32'(busy),      32'h0);
      rsp_ready = 2'b00;

      // Reset pulse so round robin starts from pointer 0
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;

      // Round robin with both requesters continuously valid
      rsp_ready = 2'b11;
      req_a = {32'h0000_00F0, 32'd10}; req_b = {32'h0000_000F, 32'd4};
      req_op = {4'b0011, 4'b0001}; req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_grant", 32'(req_ready), 32'(1 << (i % 2)));
         tick();
         tick();
         chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (i % 2)));
         chk("rr_result", rsp_result, (i % 2 == 1) ? 32'h0000_00FF : 32'd6);
         tick();
      end
      req_valid = 2'b00; rsp_ready = 2'b00;

      // Response backpressure on requester 1
      req_a = {32'h8000_0000, 32'hFFFF_FFFF}; req_b = {32'd4, 32'd1};
      req_op = {4'b0111, 4'b1000}; req_valid = 2'b10;
      #1;
      chk("bp_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b01;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
         chk("bp_result",    rsp_result,     32'hF800_0000);
         chk("bp_req_ready", 32'(req_ready), 32'h0);
         tick();
      end
      rsp_ready = 2'b10;
      #1;
      chk("bp_hold_last", 32'(rsp_valid), 32'h2);
      tick();
      chk("bp_next_grant", 32'(req_ready), 32'h1);
      chk("bp_rsp_clear",  32'(rsp_valid), 32'h0);
      tick();
      tick();
      chk("slt_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("slt_result",    rsp_result,     32'd1);
      tick();
      chk("nonowner_ignored", 32'(rsp_valid), 32'h1);
      rsp_ready = 2'b01;
      req_op = {4'b0111, 4'b1001};
      tick();
      chk("sltu_grant", 32'(req_ready), 32'h1);
      tick();
      tick();
      chk("sltu_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("sltu_result",    rsp_result,     32'd0);
      req_valid = 2'b00;
      tick();

      // Reset during EXEC
      req_a = {32'd0, 32'd7}; req_b = {32'd0, 32'd7}; req_op = {4'b0000, 4'b1100};
      req_valid = 2'b01;
      #1;
      chk("mr_grant", 32'(req_ready), 32'h1);
      tick();
      chk("mr_exec_busy", 32'(busy), 32'h1);
      chk("mr_exec_a",    alu_a,     32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mr_req_ready", 32'(req_ready), 32'h0);
      chk("mr_busy",      32'(busy),      32'h0);
      chk("mr_alu_a",     alu_a,          32'h0);
      chk("mr_alu_b",     alu_b,          32'h0);
      chk("mr_alu_op",    32'(alu_op),    32'h0);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
      end
      req_valid = 2'b11;
      #1;
      chk("mr_prio0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      tick();
      chk("mr_seq_result", rsp_result, 32'd1);
      tick();
      rsp_ready = 2'b00;

      // Pointer wrap on the three-requester instance
      a3 = {32'd20, 32'd0, 32'd1}; b3 = {32'd5, 32'd0, 32'd2};
      op3 = {4'b0001, 4'b0000, 4'b0000}; v3 = 3'b100;
      #1;
      chk("wrap_grant2", 32'(rdy3), 32'h4);
      tick();
      v3 = 3'b101;
      tick();
      chk("wrap_rsp2",    32'(rv3), 32'h4);
      chk("wrap_result2", res3,     32'd15);
      tick();
      chk("wrap_grant0", 32'(rdy3), 32'h1);
      tick();
      tick();
      chk("wrap_rsp0",    32'(rv3), 32'h1);
      chk("wrap_result0", res3,     32'd3);
      tick();
      chk("wrap_grant2_again", 32'(rdy3), 32'h4);
      v3 = 3'b000;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
